// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared format codes and defaults for the immediate generator
package imm_gen_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_Z    = 3'd5,
        FMT_SH   = 3'd6,
        FMT_RSVD = 3'd7
    } imm_fmt_e;

endpackage

// File: rtl/imm_gen_core.sv
// rtl/imm_gen_core.sv - combinational immediate extraction from one instruction word
module imm_gen_core
    import imm_gen_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      fmt,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    logic [31:0] raw;
    logic        sext;

    // Assemble the field as a 32-bit value, then widen it (sign or zero) to XLEN
    always_comb begin
        raw  = '0;
        sext = 1'b0;
        err  = 1'b0;
        case (imm_fmt_e'(fmt))
            FMT_I: begin
                raw  = {{20{inst[31]}}, inst[31:20]};
                sext = 1'b1;
            end
            FMT_S: begin
                raw  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                sext = 1'b1;
            end
            FMT_B: begin
                raw  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                sext = 1'b1;
            end
            FMT_U: begin
                raw  = {inst[31:12], 12'b0};
                sext = 1'b1;
            end
            FMT_J: begin
                raw  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                sext = 1'b1;
            end
            FMT_Z: begin
                raw = {27'b0, inst[19:15]};
            end
            FMT_SH: begin
                // RV64 shift amounts use six bits, RV32 only five
                raw = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
            end
            FMT_RSVD: begin
                err = 1'b1;
            end
        endcase
        imm = sext ? XLEN'($signed(raw)) : XLEN'(raw);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate generator with a DEPTH-entry output FIFO and valid/ready handshake
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [2:0]      in_fmt,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_err
);

    localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [2:0]       DEPTH_CNT = 3'(DEPTH);

    logic [XLEN-1:0]  core_imm;
    logic             core_err;
    logic [XLEN-1:0]  imm_mem_q [DEPTH];
    logic [DEPTH-1:0] err_mem_q;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [2:0]       count_q, count_d;
    logic             ready_en_q;
    logic             push;
    logic             pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    imm_gen_core #(
        .XLEN (XLEN)
    ) u_core (
        .inst (in_inst),
        .fmt  (in_fmt),
        .imm  (core_imm),
        .err  (core_err)
    );

    // in_ready depends only on registered state, so out_ready never reaches it;
    // ready_en_q keeps it low while reset is held and for no longer
    assign in_ready  = ready_en_q && (count_q < DEPTH_CNT);
    assign out_valid = (count_q != 3'd0);
    assign out_imm   = out_valid ? imm_mem_q[rptr_q] : '0;
    assign out_err   = out_valid & err_mem_q[rptr_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next pointer/occupancy; flush wins over any push or pop in the same cycle
    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (flush) begin
            count_d = 3'd0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            if (push) wptr_d = ptr_inc(wptr_q);
            if (pop)  rptr_d = ptr_inc(rptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state, cleared immediately by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 3'd0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            ready_en_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            ready_en_q <= 1'b1;
        end
    end

    // Entry storage; contents are don't-care while count marks them empty
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            imm_mem_q[wptr_q] <= core_imm;
            err_mem_q[wptr_q] <= core_err;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [2:0]  in_fmt;
    logic        flush;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] got_q[$];

    typedef struct {
        string       name;
        logic [2:0]  fmt;
        logic [31:0] inst;
        logic [31:0] exp32;
        logic [63:0] exp64;
        logic        err;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready32),
        .in_inst   (in_inst),
        .in_fmt    (in_fmt),
        .flush     (flush),
        .out_valid (out_valid32),
        .out_ready (out_ready),
        .out_imm   (out_imm32),
        .out_err   (out_err32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(2)) dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready64),
        .in_inst   (in_inst),
        .in_fmt    (in_fmt),
        .flush     (flush),
        .out_valid (out_valid64),
        .out_ready (out_ready),
        .out_imm   (out_imm64),
        .out_err   (out_err64)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with inputs already driven; records any pop, then advances one cycle
    task automatic tick();
        #1;
        if (out_valid32 && out_ready) got_q.push_back(out_imm32);
        @(negedge clk);
    endtask

    function automatic logic [31:0] i_word(input logic [11:0] imm12);
        return {imm12, 20'h00093};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{"I_neg",   3'd0, 32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1]  = '{"S_pos",   3'd1, 32'h0020A423, 32'h00000008, 64'h0000000000000008, 1'b0};
        vecs[2]  = '{"B_neg",   3'd2, 32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[3]  = '{"U_pos",   3'd3, 32'h123450B7, 32'h12345000, 64'h0000000012345000, 1'b0};
        vecs[4]  = '{"J_pos",   3'd4, 32'h0010006F, 32'h00000800, 64'h0000000000000800, 1'b0};
        vecs[5]  = '{"U_neg",   3'd3, 32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
        vecs[6]  = '{"SH_3f",   3'd6, 32'h03F00013, 32'h0000001F, 64'h000000000000003F, 1'b0};
        vecs[7]  = '{"Z_1f",    3'd5, 32'h000F8073, 32'h0000001F, 64'h000000000000001F, 1'b0};
        vecs[8]  = '{"Z_noext", 3'd5, 32'hFFF7FFFF, 32'h0000000F, 64'h000000000000000F, 1'b0};
        vecs[9]  = '{"I_pos",   3'd0, 32'h7FF00013, 32'h000007FF, 64'h00000000000007FF, 1'b0};
        vecs[10] = '{"RSVD",    3'd7, 32'hFFFFFFFF, 32'h00000000, 64'h0000000000000000, 1'b1};
        vecs[11] = '{"J_neg",   3'd4, 32'h8000006F, 32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
        vecs[12] = '{"S_neg",   3'd1, 32'hFE000FA3, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_fmt    = 3'd0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // Reset state, before any clock edge
        #2;
        check("rst_in_ready",  in_ready32,  1'b0);
        check("rst_out_valid", out_valid32, 1'b0);
        check("rst_out_imm",   out_imm32,   32'h0);
        check("rst_out_err",   out_err32,   1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rdy_before_edge", in_ready32, 1'b0);
        @(negedge clk);
        check("rdy_after_edge32", in_ready32, 1'b1);
        check("rdy_after_edge64", in_ready64, 1'b1);

        // Format table, one-cycle latency, sink always ready
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_fmt   = vecs[i].fmt;
            in_inst  = vecs[i].inst;
            #1;
            check({vecs[i].name, "_in_ready"}, in_ready32, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check({vecs[i].name, "_valid32"}, out_valid32, 1'b1);
            check({vecs[i].name, "_imm32"},   out_imm32,   vecs[i].exp32);
            check({vecs[i].name, "_err32"},   out_err32,   vecs[i].err);
            check({vecs[i].name, "_imm64"},   out_imm64,   vecs[i].exp64);
            check({vecs[i].name, "_err64"},   out_err64,   vecs[i].err);
            @(negedge clk);
        end
        check("table_drained", out_valid32, 1'b0);

        // Backpressure: three words offered into a two-entry buffer
        got_q.delete();
        out_ready = 1'b0;
        in_fmt    = 3'd0;
        in_valid  = 1'b1;
        in_inst   = i_word(12'h011);
        tick();
        in_inst   = i_word(12'h022);
        tick();
        check("bp_full_ready", in_ready32, 1'b0);
        in_inst   = i_word(12'h033);
        check("bp_head", out_imm32, 32'h11);
        tick();
        check("bp_hold_imm",   out_imm32,   32'h11);
        check("bp_hold_valid", out_valid32, 1'b1);
        out_ready = 1'b1;
        check("bp_full_pop_ready", in_ready32, 1'b0);
        tick();
        check("bp_ready_back", in_ready32, 1'b1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("bp_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("bp_order0", got_q[0], 32'h11);
            check("bp_order1", got_q[1], 32'h22);
            check("bp_order2", got_q[2], 32'h33);
        end

        // Simultaneous push and pop with one entry resident
        got_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = i_word(12'h100);
        tick();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_inst = i_word(12'h100 + 12'(i));
            check("pp_in_ready",  in_ready32,  1'b1);
            check("pp_out_valid", out_valid32, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("pp_drained", out_valid32, 1'b0);
        check("pp_count", got_q.size(), 11);
        if (got_q.size() == 11) begin
            for (int i = 0; i < 11; i++) begin
                check("pp_order", got_q[i], 32'h100 + 32'(i));
            end
        end

        // Flush at count=2 with a word offered
        got_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = i_word(12'h201);
        tick();
        in_inst   = i_word(12'h202);
        tick();
        in_inst   = i_word(12'h2FF);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        check("fl2_valid", out_valid32, 1'b0);
        check("fl2_imm",   out_imm32,   32'h0);
        check("fl2_err",   out_err32,   1'b0);
        check("fl2_ready", in_ready32,  1'b1);

        // Flush at count=1 where the concurrent push would otherwise be taken
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = i_word(12'h203);
        tick();
        in_inst   = i_word(12'h2FE);
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush     = 1'b0;
        in_valid  = 1'b0;
        check("fl1_valid", out_valid32, 1'b0);
        tick();
        check("fl1_no_ghost_valid", out_valid32, 1'b0);
        in_valid  = 1'b1;
        in_inst   = i_word(12'h204);
        tick();
        in_valid  = 1'b0;
        check("fl_after_valid", out_valid32, 1'b1);
        check("fl_after_imm",   out_imm32,   32'h204);
        tick();
        begin
            int ghosts = 0;
            foreach (got_q[i]) if (got_q[i] == 32'h2FF || got_q[i] == 32'h2FE) ghosts++;
            check("fl_no_ghost", ghosts, 0);
        end

        // Reset asserted between clock edges with two entries buffered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = i_word(12'h301);
        tick();
        in_inst   = i_word(12'h302);
        tick();
        in_valid  = 1'b0;
        check("mr_pre_valid", out_valid32, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid32", out_valid32, 1'b0);
        check("mr_imm32",   out_imm32,   32'h0);
        check("mr_err32",   out_err32,   1'b0);
        check("mr_ready32", in_ready32,  1'b0);
        check("mr_valid64", out_valid64, 1'b0);
        check("mr_imm64",   out_imm64,   64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_ready_after", in_ready32,  1'b1);
        check("mr_empty_after", out_valid32, 1'b0);
        out_ready = 1'b1;
        tick();
        check("mr_no_reappear", out_valid32, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 2, output buffer entries; legal values 1 to 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the instruction word is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-007 SHALL have port in_inst, input, 32 bits: the full instruction word.
REQ-008 SHALL have port in_fmt, input, 3 bits: immediate format code, per REQ-012.
REQ-009 SHALL have port flush, input, 1 bit: discard all buffered entries.
REQ-010 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_imm (output, XLEN bits) and out_err (output, 1 bit: entry had an illegal format code).

Function
REQ-011 SHALL accept a word when in_valid and in_ready are both high at a rising edge, and SHALL pop the head entry when out_valid and out_ready are both high.
REQ-012 Format codes SHALL be:
- 0 I: inst[31:20], sign-extended.
- 1 S: {inst[31:25], inst[11:7]}, sign-extended.
- 2 B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
- 3 U: {inst[31:12], 12 zeros}, sign-extended to XLEN.
- 4 J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
- 5 Z: inst[19:15], zero-extended (CSR uimm).
- 6 SH: inst[25:20] if XLEN=64, else inst[24:20], zero-extended.
- 7: out_imm=0 and out_err=1.
REQ-013 Latency SHALL be one cycle: a word accepted into an empty buffer shows out_valid=1 with its immediate in the next cycle.
REQ-014 The buffer SHALL be a FIFO of DEPTH entries; entries SHALL leave in acceptance order.
REQ-015 in_ready SHALL equal (count < DEPTH) and SHALL be registered or derived from count only; there SHALL be no combinational path from out_ready to in_ready.
REQ-016 When the buffer is full, in_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-017 A push and a pop in the same cycle SHALL leave count unchanged, and the read/write pointers SHALL wrap modulo DEPTH.
REQ-018 out_imm and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 Flush SHALL act synchronously: count goes to 0 and out_valid to 0 in the next cycle. Flush SHALL take priority over a simultaneous push and pop, and the pushed word SHALL be dropped.
REQ-020 When out_valid=0, out_imm and out_err SHALL be 0.

Reset
REQ-021 While rst_n=0, the block SHALL immediately force count=0, pointers=0, out_valid=0, out_imm=0, out_err=0 and in_ready=0.
REQ-022 in_ready SHALL go to 1 on the first rising edge after rst_n deasserts.
REQ-023 Reset asserted mid-transfer SHALL discard all entries, and no partially popped entry SHALL reappear.

Structure
REQ-024 The format codes (FMT_I..FMT_SH, FMT_RSVD) and the XLEN default SHALL live in shared package imm_gen_pkg.
REQ-025 Extraction SHALL live in combinational sub-module imm_gen_core (inputs inst, fmt; outputs imm, err; parameter XLEN).
REQ-026 The FIFO and handshake SHALL live in imm_gen_pipe, in about 150 lines.

Verification
REQ-027 Formats, with XLEN=32, all ready high:
- I 0xFFF00093 -> 0xFFFFFFFF.
- S 0x0020A423 -> 0x00000008.
- B 0xFE000EE3 -> 0xFFFFFFFC.
- U 0x123450B7 -> 0x12345000.
- J 0x0010006F -> 0x00000800.
Each result SHALL appear one cycle after acceptance.
REQ-028 XLEN=64: U 0x800000B7 -> 0xFFFFFFFF80000000; SH with inst[25:20]=0x3F -> 0x000000000000003F; Z with inst[19:15]=0x1F -> 0x1F.
REQ-029 Backpressure, DEPTH=2: hold out_ready=0 and push 3 words. in_ready SHALL drop after the 2nd word. Releasing out_ready SHALL give outputs in order with no loss or duplication.
REQ-030 Simultaneous push/pop at count=1 for 10 cycles: count SHALL stay 1 and the data order SHALL be preserved.
REQ-031 Flush with a concurrent push at count=2: out_valid=0 next cycle, and the pushed word SHALL never appear. Format code 7 SHALL give out_imm=0 with out_err=1.
REQ-032 Assert rst_n=0 mid-burst: outputs SHALL go to 0 without a clock edge, and in_ready SHALL be 1 one edge after release.
